// File: rtl/sprite_blitter_if.sv
// Command/status bundle between the CPU execute stage and the sprite engine.
//   master: issues CLEAR/DRAW commands (cmd_valid, cmd_op, row, col, height, sprite_data)
//           and observes cmd_ready, busy, done, vf
//   slave : the engine side of the same signals
interface sprite_blitter_if #(
    parameter int unsigned MAX_ROWS = 15,
    parameter int unsigned SPRITE_W = 8
);
    localparam int unsigned HW = $clog2(MAX_ROWS + 1);

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic                         cmd_op;
    logic [7:0]                   row;
    logic [7:0]                   col;
    logic [HW-1:0]                height;
    logic [MAX_ROWS*SPRITE_W-1:0] sprite_data;
    logic                         busy;
    logic                         done;
    logic [7:0]                   vf;

    modport master (
        output cmd_valid, cmd_op, row, col, height, sprite_data,
        input  cmd_ready, busy, done, vf
    );

    modport slave (
        input  cmd_valid, cmd_op, row, col, height, sprite_data,
        output cmd_ready, busy, done, vf
    );
endinterface

// File: rtl/sprite_blitter.sv
// CHIP-8/SCHIP sprite engine: owns the framebuffer, runs CLEAR (one row per
// cycle) and DRAW (one XORed sprite row per cycle, with collision -> VF),
// and provides a registered scanout read port.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : command handshake and status (sprite_blitter_if.slave)
//   fb_rd_row  : scanout row address
//   fb_rd_data : scanout row, 1-cycle latency, bit c = column c
module sprite_blitter #(
    parameter int unsigned SCREEN_W = 64,
    parameter int unsigned SCREEN_H = 32,
    parameter int unsigned SPRITE_W = 8,
    parameter int unsigned MAX_ROWS = 15,
    parameter int unsigned WRAP     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    sprite_blitter_if.slave             bus,
    input  logic [$clog2(SCREEN_H)-1:0] fb_rd_row,
    output logic [SCREEN_W-1:0]         fb_rd_data
);
    localparam int unsigned RW = $clog2(SCREEN_H);
    localparam int unsigned CW = $clog2(SCREEN_W);
    localparam int unsigned HW = $clog2(MAX_ROWS + 1);
    localparam int unsigned IW = (RW > HW) ? RW : HW;
    localparam int unsigned RF = RW + HW;
    localparam int unsigned DW = MAX_ROWS * SPRITE_W;

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, DONE} state_t;

    state_t              state, state_next;
    logic [IW-1:0]       idx;
    logic [RW-1:0]       row_q;
    logic [CW-1:0]       col_q;
    logic [HW-1:0]       h_q;
    logic [DW-1:0]       spr_q;
    logic                coll_q;
    logic [SCREEN_W-1:0] fb [SCREEN_H];
    logic                ready_q, busy_q, done_q;
    logic [7:0]          vf_q;

    logic [HW-1:0]       h_in;
    logic [SPRITE_W-1:0] sprite_row;
    logic [RW-1:0]       r_idx;
    logic                r_in;
    logic [SCREEN_W-1:0] mask;
    logic [SCREEN_W-1:0] old_row;
    logic                coll_row;
    logic                last_draw, last_clear;
    logic                ready_n, busy_n, done_n;

    // Only the low address bits matter: row/col are taken modulo the screen size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.row[7:RW], bus.col[7:CW]};

    assign bus.cmd_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.vf        = vf_q;

    // Row datapath: current sprite row is always the top slice of the shifting spr_q.
    always_comb begin
        h_in       = (bus.height > HW'(MAX_ROWS)) ? HW'(MAX_ROWS) : bus.height;
        sprite_row = spr_q[DW-1 -: SPRITE_W];
        r_idx      = row_q + RW'(idx);
        r_in       = (WRAP != 0) || ((RF'(row_q) + RF'(idx)) < RF'(SCREEN_H));
        mask       = '0;
        for (int j = 0; j < int'(SPRITE_W); j++) begin
            // CW-bit column sum wraps naturally; the range test only matters when clipping.
            if (sprite_row[SPRITE_W-1-j] &&
                ((WRAP != 0) || ((CW+1)'(col_q) + (CW+1)'(j) < (CW+1)'(SCREEN_W)))) begin
                mask[col_q + CW'(j)] = 1'b1;
            end
        end
        old_row    = fb[r_idx];
        coll_row   = r_in && (|(old_row & mask));
        last_draw  = (IW'(h_q) == idx + IW'(1));
        last_clear = (idx == IW'(SCREEN_H - 1));
    end

    // Next state and next values of the registered status outputs.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (!bus.cmd_op)          state_next = CLEAR;
                    else if (h_in == '0)      state_next = DONE;
                    else                      state_next = DRAW;
                end
            end
            CLEAR:   if (last_clear) state_next = DONE;
            DRAW:    if (last_draw)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        ready_n = (state_next == IDLE);
        busy_n  = (state_next != IDLE);
        done_n  = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            h_q        <= '0;
            spr_q      <= '0;
            coll_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vf_q       <= 8'h00;
            fb_rd_data <= '0;
            for (int i = 0; i < int'(SCREEN_H); i++) begin
                fb[i] <= '0;
            end
        end else begin
            state      <= state_next;
            ready_q    <= ready_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            fb_rd_data <= fb[fb_rd_row];
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        row_q  <= bus.row[RW-1:0];
                        col_q  <= bus.col[CW-1:0];
                        h_q    <= h_in;
                        spr_q  <= bus.sprite_data;
                        coll_q <= 1'b0;
                        idx    <= '0;
                        // Zero-height DRAW completes immediately with no collision.
                        if (bus.cmd_op && (h_in == '0)) vf_q <= 8'h00;
                    end
                end
                CLEAR: begin
                    fb[idx[RW-1:0]] <= '0;
                    idx             <= idx + IW'(1);
                end
                DRAW: begin
                    if (r_in) fb[r_idx] <= old_row ^ mask;
                    coll_q <= coll_q | coll_row;
                    spr_q  <= spr_q << SPRITE_W;
                    idx    <= idx + IW'(1);
                    // Include the final row's collision, which lands on this same edge.
                    if (last_draw) vf_q <= {7'b0, coll_q | coll_row};
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter: one clipping (WRAP=0) and one
// wrapping (WRAP=1) instance receive identical commands.
module tb_sprite_blitter;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  fb_rd_row;
    logic [63:0] fb_rd_data0, fb_rd_data1;
    int          checks   = 0;
    int          failures = 0;
    int          lat;
    int          ndone;
    logic [63:0] d0, d1;

    always #5 clk = ~clk;

    sprite_blitter_if #(.MAX_ROWS(15), .SPRITE_W(8)) if0 ();
    sprite_blitter_if #(.MAX_ROWS(15), .SPRITE_W(8)) if1 ();

    assign if1.cmd_valid   = if0.cmd_valid;
    assign if1.cmd_op      = if0.cmd_op;
    assign if1.row         = if0.row;
    assign if1.col         = if0.col;
    assign if1.height      = if0.height;
    assign if1.sprite_data = if0.sprite_data;

    sprite_blitter #(.WRAP(0)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave),
        .fb_rd_row(fb_rd_row), .fb_rd_data(fb_rd_data0)
    );

    sprite_blitter #(.WRAP(1)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave),
        .fb_rd_row(fb_rd_row), .fb_rd_data(fb_rd_data1)
    );

    // Compare one observed value against its expectation and record the result.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command in an idle cycle and release it right after the accepting edge.
    task automatic issue(input logic op, input logic [7:0] r, input logic [7:0] c,
                         input logic [3:0] h, input logic [119:0] d);
        @(negedge clk);
        if0.cmd_valid   = 1'b1;
        if0.cmd_op      = op;
        if0.row         = r;
        if0.col         = c;
        if0.height      = h;
        if0.sprite_data = d;
        @(posedge clk);
        #1;
        if0.cmd_valid = 1'b0;
    endtask

    // Cycles after the accepting edge until done is seen; 0 (and a failure) if it never appears.
    task automatic wait_done(output int l);
        l = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (if0.done) begin
                l = k;
                break;
            end
        end
        checks++;
        if (l == 0) begin
            failures++;
            $error("FAIL wait_done: done not seen within 100 cycles");
        end
    endtask

    task automatic rd(input logic [4:0] r, output logic [63:0] a, output logic [63:0] b);
        @(negedge clk);
        fb_rd_row = r;
        @(negedge clk);
        a = fb_rd_data0;
        b = fb_rd_data1;
    endtask

    initial begin
        rst             = 1'b1;
        fb_rd_row       = '0;
        if0.cmd_valid   = 1'b0;
        if0.cmd_op      = 1'b0;
        if0.row         = '0;
        if0.col         = '0;
        if0.height      = '0;
        if0.sprite_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_ready", 64'(if0.cmd_ready), 64'h1);
        chk("rst_busy",  64'(if0.busy),      64'h0);
        chk("rst_done",  64'(if0.done),      64'h0);
        chk("rst_vf",    64'(if0.vf),        64'h00);
        rd(5'd0, d0, d1);
        chk("rst_row0",  d0, 64'h0);

        // DRAW F0 at (0,0): columns 0-3 of row 0
        issue(1'b1, 8'd0, 8'd0, 4'd1, {8'hF0, 112'h0});
        wait_done(lat);
        chk("t1_lat", 64'(lat), 64'd2);
        chk("t1_vf",  64'(if0.vf), 64'h00);
        rd(5'd0, d0, d1);
        chk("t1_row0", d0, 64'h0000_0000_0000_000F);

        // Same sprite again erases it and collides
        issue(1'b1, 8'd0, 8'd0, 4'd1, {8'hF0, 112'h0});
        wait_done(lat);
        chk("t2_lat", 64'(lat), 64'd2);
        chk("t2_vf",  64'(if0.vf), 64'h01);
        rd(5'd0, d0, d1);
        chk("t2_row0", d0, 64'h0);

        // Empty area: no collision, pixels at cols 20 and 27 of row 10
        issue(1'b1, 8'd10, 8'd20, 4'd1, {8'h81, 112'h0});
        wait_done(lat);
        chk("t2b_vf", 64'(if0.vf), 64'h00);
        rd(5'd10, d0, d1);
        chk("t2b_row10", d0, 64'h0000_0000_0810_0000);

        // Corner sprite: clipped on u0, wrapped on u1
        issue(1'b1, 8'd31, 8'd62, 4'd2, {8'hFF, 8'hFF, 104'h0});
        wait_done(lat);
        chk("t3_lat", 64'(lat), 64'd3);
        chk("t3_vf0", 64'(if0.vf), 64'h00);
        chk("t3_vf1", 64'(if1.vf), 64'h00);
        rd(5'd31, d0, d1);
        chk("t3_clip_row31", d0, 64'hC000_0000_0000_0000);
        chk("t3_wrap_row31", d1, 64'hC000_0000_0000_003F);
        rd(5'd0, d0, d1);
        chk("t3_clip_row0", d0, 64'h0);
        chk("t3_wrap_row0", d1, 64'hC000_0000_0000_003F);

        // Out-of-range coordinates reduce modulo screen: (33,70) -> (1,6)
        issue(1'b1, 8'd33, 8'd70, 4'd1, {8'h80, 112'h0});
        wait_done(lat);
        chk("t4_lat", 64'(lat), 64'd2);
        rd(5'd1, d0, d1);
        chk("t4_row1", d0, 64'h0000_0000_0000_0040);

        // Full-height sprite: done at T+16, then redraw to collide
        issue(1'b1, 8'd0, 8'd0, 4'd15, {15{8'h01}});
        wait_done(lat);
        chk("t4_h15_lat", 64'(lat), 64'd16);
        chk("t4_h15_vf",  64'(if0.vf), 64'h00);
        rd(5'd14, d0, d1);
        chk("t4_h15_row14", d0, 64'h0000_0000_0000_0080);
        issue(1'b1, 8'd0, 8'd0, 4'd15, {15{8'h01}});
        wait_done(lat);
        chk("t4_h15b_vf", 64'(if0.vf), 64'h01);
        rd(5'd14, d0, d1);
        chk("t4_h15b_row14", d0, 64'h0);

        // Zero height: immediate done, vf forced to 0
        issue(1'b1, 8'd0, 8'd0, 4'd0, {120{1'b1}});
        wait_done(lat);
        chk("t4_h0_lat", 64'(lat), 64'd1);
        chk("t4_h0_vf",  64'(if0.vf), 64'h00);

        // CLEAR timing, then fill the whole screen
        issue(1'b0, 8'd0, 8'd0, 4'd0, 120'h0);
        wait_done(lat);
        chk("t5_clr_lat", 64'(lat), 64'd33);
        for (int cb = 0; cb < 64; cb += 8) begin
            issue(1'b1, 8'd0,  8'(cb), 4'd15, {120{1'b1}});
            wait_done(lat);
            issue(1'b1, 8'd15, 8'(cb), 4'd15, {120{1'b1}});
            wait_done(lat);
            issue(1'b1, 8'd30, 8'(cb), 4'd2,  {120{1'b1}});
            wait_done(lat);
        end
        chk("t5_fill_vf", 64'(if0.vf), 64'h00);
        rd(5'd17, d0, d1);
        chk("t5_fill_row17", d0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t5_fill_row17_wrap", d1, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(1'b1, 8'd0, 8'd0, 4'd1, {8'hFF, 112'h0});
        wait_done(lat);
        chk("t5_pre_vf", 64'(if0.vf), 64'h01);

        // CLEAR with a command pulsed mid-way: dropped, vf untouched
        issue(1'b0, 8'd0, 8'd0, 4'd0, 120'h0);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 5) begin
                chk("t5_mid_ready", 64'(if0.cmd_ready), 64'h0);
                chk("t5_mid_busy",  64'(if0.busy),      64'h1);
                if0.cmd_valid   = 1'b1;
                if0.cmd_op      = 1'b1;
                if0.row         = 8'd5;
                if0.col         = 8'd5;
                if0.height      = 4'd1;
                if0.sprite_data = {8'hFF, 112'h0};
            end
            if (k == 6) if0.cmd_valid = 1'b0;
            if (if0.done) begin
                lat = k;
                break;
            end
        end
        chk("t5_lat", 64'(lat), 64'd33);
        chk("t5_vf",  64'(if0.vf), 64'h01);
        repeat (3) @(negedge clk);
        chk("t5_idle_busy", 64'(if0.busy), 64'h0);
        rd(5'd0, d0, d1);
        chk("t5_row0", d0, 64'h0);
        rd(5'd5, d0, d1);
        chk("t5_row5", d0, 64'h0);
        chk("t5_row5_wrap", d1, 64'h0);
        rd(5'd31, d0, d1);
        chk("t5_row31", d0, 64'h0);

        // Reset during a 10-row DRAW, with a command offered while in reset
        issue(1'b1, 8'd0, 8'd0, 4'd10, {120{1'b1}});
        repeat (2) @(negedge clk);
        @(negedge clk);
        rst             = 1'b1;
        if0.cmd_valid   = 1'b1;
        if0.cmd_op      = 1'b1;
        if0.row         = 8'd3;
        if0.col         = 8'd3;
        if0.height      = 4'd1;
        if0.sprite_data = {8'h80, 112'h0};
        @(negedge clk);
        chk("t6_ready", 64'(if0.cmd_ready), 64'h1);
        chk("t6_vf",    64'(if0.vf),        64'h00);
        @(negedge clk);
        rst           = 1'b0;
        if0.cmd_valid = 1'b0;
        chk("t6_busy",  64'(if0.busy), 64'h0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (if0.done) ndone++;
        end
        chk("t6_no_done", 64'(ndone), 64'd0);
        rd(5'd0, d0, d1);
        chk("t6_row0", d0, 64'h0);
        rd(5'd3, d0, d1);
        chk("t6_row3", d0, 64'h0);
        rd(5'd20, d0, d1);
        chk("t6_row20", d0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
